// File: rtl/sram_avalon_responder_if.sv
// ----------------------------------------------------------------------------
// sram_avalon_responder_if
// Avalon-MM "s1" command/response bundle shared by the bus master and the
// SRAM-backed responder.
//   s1_address       [22:0] word address                 (master -> slave)
//   s1_byteenable_n  [3:0]  active-low byte enables      (master -> slave)
//   s1_chipselect           command qualifier            (master -> slave)
//   s1_writedata     [31:0] write word                   (master -> slave)
//   s1_read_n               active-low read              (master -> slave)
//   s1_write_n              active-low write             (master -> slave)
//   s1_readdata      [31:0] registered read word         (slave -> master)
//   s1_readdatavalid        one-cycle read data qualifier(slave -> master)
//   s1_waitrequest          high = command not accepted  (slave -> master)
// ----------------------------------------------------------------------------
interface sram_avalon_responder_if;
   logic [22:0] s1_address;
   logic [3:0]  s1_byteenable_n;
   logic        s1_chipselect;
   logic [31:0] s1_writedata;
   logic        s1_read_n;
   logic        s1_write_n;
   logic [31:0] s1_readdata;
   logic        s1_readdatavalid;
   logic        s1_waitrequest;

   modport master (
      output s1_address, s1_byteenable_n, s1_chipselect, s1_writedata,
             s1_read_n, s1_write_n,
      input  s1_readdata, s1_readdatavalid, s1_waitrequest
   );

   modport slave (
      input  s1_address, s1_byteenable_n, s1_chipselect, s1_writedata,
             s1_read_n, s1_write_n,
      output s1_readdata, s1_readdatavalid, s1_waitrequest
   );
endinterface

// File: rtl/sram_avalon_responder.sv
// ----------------------------------------------------------------------------
// sram_avalon_responder
// Avalon-MM slave that services 32-bit word commands on the s1 port from a
// 16-bit asynchronous SRAM, splitting each word into a low and a high
// halfword SRAM cycle (setup / strobe x ACCESS_CYCLES / recover each).
// Words whose address has any of bits [22:19] set are out of range: they run
// with identical timing but never assert an SRAM strobe; reads return zero.
//
// Parameters
//   ACCESS_CYCLES  strobe cycles per halfword access (minimum 1)
// Ports
//   i_clk          system clock
//   i_rst          asynchronous active-low reset
//   s1             Avalon-MM slave bundle (see sram_avalon_responder_if)
//   SRAM_DQ[15:0]  SRAM data bus (driven only during write halfword cycles)
//   SRAM_ADDR[19:0] SRAM halfword address
//   SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  active-low strobes
// All SRAM pins and all s1 outputs come straight from registers.
// ----------------------------------------------------------------------------
module sram_avalon_responder #(
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   sram_avalon_responder_if.slave  s1,
   inout  wire  [15:0]             SRAM_DQ,
   output logic [19:0]             SRAM_ADDR,
   output logic                    SRAM_CE_N,
   output logic                    SRAM_OE_N,
   output logic                    SRAM_WE_N,
   output logic                    SRAM_UB_N,
   output logic                    SRAM_LB_N
);

   // A zero or negative setting would make the strobe phase vanish; clamp it.
   localparam int N_ACC = (ACCESS_CYCLES < 1) ? 1 : ACCESS_CYCLES;
   localparam int CNT_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LO_SETUP   = 3'd1,
      ST_LO_STROBE  = 3'd2,
      ST_LO_RECOVER = 3'd3,
      ST_HI_SETUP   = 3'd4,
      ST_HI_STROBE  = 3'd5,
      ST_HI_RECOVER = 3'd6,
      ST_ACK        = 3'd7
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;

   // Captured command (only the parts still needed after the low halfword)
   logic             is_write_r;
   logic             in_range_r;
   logic [1:0]       be_hi_n_r;
   logic [15:0]      wdata_hi_r;

   // Read halfword holding registers and s1 response registers
   logic [15:0]      lo_r;
   logic [15:0]      hi_r;
   logic [31:0]      readdata_r;
   logic             rdv_r;
   logic             waitreq_r;

   // SRAM pin registers
   logic [19:0]      sram_addr_r;
   logic             ce_n_r;
   logic             oe_n_r;
   logic             we_n_r;
   logic             ub_n_r;
   logic             lb_n_r;
   logic [15:0]      dq_out_r;
   logic             dq_oe_r;

   logic             cmd_pending_s;
   logic             cmd_write_s;
   logic             in_range_s;
   logic             rd_active_s;
   logic             wr_active_s;

   // A write wins when both read_n and write_n are low.
   assign cmd_pending_s = s1.s1_chipselect & (~s1.s1_read_n | ~s1.s1_write_n);
   assign cmd_write_s   = ~s1.s1_write_n;
   assign in_range_s    = (s1.s1_address[22:19] == 4'd0);

   // Strobe qualifiers for the captured command; out-of-range never strobes.
   assign rd_active_s   = in_range_r & ~is_write_r;
   assign wr_active_s   = in_range_r &  is_write_r;

   assign SRAM_DQ          = dq_oe_r ? dq_out_r : 16'hzzzz;
   assign SRAM_ADDR        = sram_addr_r;
   assign SRAM_CE_N        = ce_n_r;
   assign SRAM_OE_N        = oe_n_r;
   assign SRAM_WE_N        = we_n_r;
   assign SRAM_UB_N        = ub_n_r;
   assign SRAM_LB_N        = lb_n_r;
   assign s1.s1_readdata      = readdata_r;
   assign s1.s1_readdatavalid = rdv_r;
   assign s1.s1_waitrequest   = waitreq_r;

   // Sequencer: command capture, two halfword SRAM cycles, ack and read response.
   // Every output is set on the edge that enters the state it belongs to, so
   // pins are glitch-free and OE_N/WE_N never move on the edge that changes
   // ADDR or DQ (those change only on SETUP entry).
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         is_write_r  <= 1'b0;
         in_range_r  <= 1'b0;
         be_hi_n_r   <= 2'b11;
         wdata_hi_r  <= 16'h0000;
         lo_r        <= 16'h0000;
         hi_r        <= 16'h0000;
         readdata_r  <= 32'h0000_0000;
         rdv_r       <= 1'b0;
         waitreq_r   <= 1'b1;
         sram_addr_r <= 20'h00000;
         ce_n_r      <= 1'b1;
         oe_n_r      <= 1'b1;
         we_n_r      <= 1'b1;
         ub_n_r      <= 1'b1;
         lb_n_r      <= 1'b1;
         dq_out_r    <= 16'h0000;
         dq_oe_r     <= 1'b0;
      end else begin
         rdv_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cmd_pending_s) begin
                  is_write_r         <= cmd_write_s;
                  in_range_r         <= in_range_s;
                  be_hi_n_r          <= s1.s1_byteenable_n[3:2];
                  wdata_hi_r         <= s1.s1_writedata[31:16];
                  sram_addr_r        <= {s1.s1_address[18:0], 1'b0};
                  ce_n_r             <= ~in_range_s;
                  {ub_n_r, lb_n_r}   <= in_range_s ? s1.s1_byteenable_n[1:0] : 2'b11;
                  dq_out_r           <= s1.s1_writedata[15:0];
                  dq_oe_r            <= in_range_s & cmd_write_s;
                  state_r            <= ST_LO_SETUP;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LO_SETUP: begin
               cnt_r   <= CNT_ZERO;
               oe_n_r  <= ~rd_active_s;
               we_n_r  <= ~wr_active_s;
               state_r <= ST_LO_STROBE;
            end
            ST_LO_STROBE: begin
               if (cnt_r == CNT_LAST) begin
                  // Sample on the edge ending the last strobe cycle.
                  lo_r    <= rd_active_s ? SRAM_DQ : 16'h0000;
                  oe_n_r  <= 1'b1;
                  we_n_r  <= 1'b1;
                  state_r <= ST_LO_RECOVER;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_LO_RECOVER: begin
               // CE_N and DQ drive stay as they are; only address/lanes/data move.
               sram_addr_r      <= {sram_addr_r[19:1], 1'b1};
               {ub_n_r, lb_n_r} <= in_range_r ? be_hi_n_r : 2'b11;
               dq_out_r         <= wdata_hi_r;
               state_r          <= ST_HI_SETUP;
            end
            ST_HI_SETUP: begin
               cnt_r   <= CNT_ZERO;
               oe_n_r  <= ~rd_active_s;
               we_n_r  <= ~wr_active_s;
               state_r <= ST_HI_STROBE;
            end
            ST_HI_STROBE: begin
               if (cnt_r == CNT_LAST) begin
                  hi_r    <= rd_active_s ? SRAM_DQ : 16'h0000;
                  oe_n_r  <= 1'b1;
                  we_n_r  <= 1'b1;
                  state_r <= ST_HI_RECOVER;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_HI_RECOVER: begin
               ce_n_r    <= 1'b1;
               ub_n_r    <= 1'b1;
               lb_n_r    <= 1'b1;
               dq_oe_r   <= 1'b0;
               waitreq_r <= 1'b0;
               state_r   <= ST_ACK;
            end
            ST_ACK: begin
               waitreq_r <= 1'b1;
               if (!is_write_r) begin
                  readdata_r <= {hi_r, lo_r};
                  rdv_r      <= 1'b1;
               end else begin
                  readdata_r <= readdata_r;
               end
               state_r <= ST_IDLE;
            end
            default: begin
               ce_n_r    <= 1'b1;
               oe_n_r    <= 1'b1;
               we_n_r    <= 1'b1;
               ub_n_r    <= 1'b1;
               lb_n_r    <= 1'b1;
               dq_oe_r   <= 1'b0;
               waitreq_r <= 1'b1;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_avalon_responder.sv
// ----------------------------------------------------------------------------
// tb_sram_avalon_responder
// Directed self-checking bench for sram_avalon_responder (ACCESS_CYCLES = 2).
// A small behavioural SRAM answers the pins; expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_sram_avalon_responder;

   localparam int N_ACC = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sram_avalon_responder_if bus();

   tri1  [15:0] sram_dq;
   logic [19:0] sram_addr;
   logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

   sram_avalon_responder #(.ACCESS_CYCLES(N_ACC)) dut (
      .i_clk     (clk),
      .i_rst     (rst_n),
      .s1        (bus),
      .SRAM_DQ   (sram_dq),
      .SRAM_ADDR (sram_addr),
      .SRAM_CE_N (sram_ce_n),
      .SRAM_OE_N (sram_oe_n),
      .SRAM_WE_N (sram_we_n),
      .SRAM_UB_N (sram_ub_n),
      .SRAM_LB_N (sram_lb_n)
   );

   // Behavioural SRAM: 256 halfwords, byte-lane writes while CE_N/WE_N are low.
   logic [15:0] mem [0:255];
   logic        model_drive;
   assign model_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
   assign sram_dq     = model_drive ? mem[sram_addr[7:0]] : 16'hzzzz;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
   end

   always @(posedge clk) begin
      if (!sram_ce_n && !sram_we_n) begin
         if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
         if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
      end
   end

   // Global cycle counter (advances on each rising edge).
   int cyc_g = 0;
   always @(posedge clk) cyc_g <= cyc_g + 1;

   // Pin monitor, sampled on the falling edge.
   int wait_low_cnt = 0, ce_low_cnt = 0, ub_low_cnt = 0, lb_low_cnt = 0;
   int oe_lo_cnt = 0, oe_hi_cnt = 0, edge_viol = 0;
   int rdv_cyc_q[$];
   logic [31:0] rdv_dat_q[$];
   logic [19:0] prev_addr = 20'h0;
   logic [15:0] prev_dq = 16'hffff;
   logic        prev_oe = 1'b1, prev_we = 1'b1, prev_rst = 1'b0;

   always @(negedge clk) begin
      if (!bus.s1_waitrequest) wait_low_cnt++;
      if (!sram_ce_n) ce_low_cnt++;
      if (!sram_ce_n && !sram_ub_n) ub_low_cnt++;
      if (!sram_ce_n && !sram_lb_n) lb_low_cnt++;
      if (!sram_oe_n && !sram_addr[0]) oe_lo_cnt++;
      if (!sram_oe_n &&  sram_addr[0]) oe_hi_cnt++;
      if (bus.s1_readdatavalid) begin
         rdv_cyc_q.push_back(cyc_g);
         rdv_dat_q.push_back(bus.s1_readdata);
      end
      if (rst_n && prev_rst && ((sram_oe_n != prev_oe) || (sram_we_n != prev_we))) begin
         if (sram_addr != prev_addr) edge_viol++;
         if (sram_oe_n && prev_oe && (sram_dq != prev_dq)) edge_viol++;
      end
      prev_addr = sram_addr;
      prev_dq   = sram_dq;
      prev_oe   = sram_oe_n;
      prev_we   = sram_we_n;
      prev_rst  = rst_n;
   end

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      bus.s1_address      = 23'h0;
      bus.s1_byteenable_n = 4'hf;
      bus.s1_chipselect   = 1'b0;
      bus.s1_writedata    = 32'h0;
      bus.s1_read_n       = 1'b1;
      bus.s1_write_n      = 1'b1;
   endtask

   // Issue one command just after a rising edge; returns ack/readdatavalid
   // cycle offsets (command first seen = cycle 0) and DQ as seen during ACK.
   task automatic do_cmd(input logic wr, input logic [22:0] a, input logic [3:0] ben,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output int ack_cyc, output int rdv_cyc, output logic [15:0] dq_ack);
      int start;
      start   = cyc_g;
      ack_cyc = -1;
      rdv_cyc = -1;
      rd      = 32'h0;
      dq_ack  = 16'h0;
      bus.s1_address      = a;
      bus.s1_byteenable_n = ben;
      bus.s1_writedata    = wd;
      bus.s1_chipselect   = 1'b1;
      bus.s1_read_n       = wr;
      bus.s1_write_n      = !wr;
      for (int k = 0; k < 40 && ack_cyc < 0; k++) begin
         @(negedge clk);
         if (!bus.s1_waitrequest) begin
            ack_cyc = cyc_g - start;
            dq_ack  = sram_dq;
         end
      end
      @(posedge clk); #1;
      bus_idle();
      if (!wr) begin
         for (int k = 0; k < 20 && rdv_cyc < 0; k++) begin
            @(negedge clk);
            if (bus.s1_readdatavalid) begin
               rdv_cyc = cyc_g - start;
               rd      = bus.s1_readdata;
            end
         end
         @(posedge clk); #1;
      end
   endtask

   logic [31:0] rd;
   logic [15:0] dq_ack;
   int ack_c, rdv_c, b_wl, b_ce, b_ub, b_lb, b_ol, b_oh, base, idx, start, bad;

   task automatic snap();
      b_wl = wait_low_cnt; b_ce = ce_low_cnt; b_ub = ub_low_cnt;
      b_lb = lb_low_cnt;   b_ol = oe_lo_cnt;  b_oh = oe_hi_cnt;
   endtask

   initial begin
      bus_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check_eq("rst_waitreq",  32'(bus.s1_waitrequest), 32'h1);
      check_eq("rst_rdv",      32'(bus.s1_readdatavalid), 32'h0);
      check_eq("rst_readdata", bus.s1_readdata, 32'h0);
      check_eq("rst_strobes",  {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
      check_eq("rst_addr",     32'(sram_addr), 32'h0);
      check_eq("rst_dq_z",     32'(sram_dq), 32'hffff);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Full word write
      snap();
      do_cmd(1'b1, 23'h00010, 4'b0000, 32'hDEADBEEF, rd, ack_c, rdv_c, dq_ack);
      check_eq("wr_ack_cycle", 32'(ack_c), 32'd9);
      check_eq("wr_wait_low_cnt", 32'(wait_low_cnt - b_wl), 32'd1);
      check_eq("wr_mem_lo", 32'(mem[8'h20]), 32'hBEEF);
      check_eq("wr_mem_hi", 32'(mem[8'h21]), 32'hDEAD);

      // Read back
      snap();
      do_cmd(1'b0, 23'h00010, 4'b0000, 32'h0, rd, ack_c, rdv_c, dq_ack);
      check_eq("rd_data", rd, 32'hDEADBEEF);
      check_eq("rd_ack_cycle", 32'(ack_c), 32'd9);
      check_eq("rd_rdv_cycle", 32'(rdv_c), 32'd10);
      check_eq("rd_oe_lo_cycles", 32'(oe_lo_cnt - b_ol), 32'd2);
      check_eq("rd_oe_hi_cycles", 32'(oe_hi_cnt - b_oh), 32'd2);
      check_eq("rd_dq_z_at_ack", 32'(dq_ack), 32'hffff);

      // Partial write with byte enables 1010
      snap();
      do_cmd(1'b1, 23'h00010, 4'b1010, 32'h11223344, rd, ack_c, rdv_c, dq_ack);
      check_eq("be_ce_low_cycles", 32'(ce_low_cnt - b_ce), 32'd8);
      check_eq("be_lb_low_cycles", 32'(lb_low_cnt - b_lb), 32'd8);
      check_eq("be_ub_low_cycles", 32'(ub_low_cnt - b_ub), 32'd0);
      do_cmd(1'b0, 23'h00010, 4'b0000, 32'h0, rd, ack_c, rdv_c, dq_ack);
      check_eq("be_readback", rd, 32'hDE22BE44);

      // Seed words 0..2 (word 0 aliases the out-of-range address below)
      do_cmd(1'b1, 23'h00000, 4'b0000, 32'h0A0B0C0D, rd, ack_c, rdv_c, dq_ack);
      do_cmd(1'b1, 23'h00001, 4'b0000, 32'h11110001, rd, ack_c, rdv_c, dq_ack);
      do_cmd(1'b1, 23'h00002, 4'b0000, 32'h22220002, rd, ack_c, rdv_c, dq_ack);

      // Out of range write and read
      snap();
      do_cmd(1'b1, 23'h080000, 4'b0000, 32'h55AA55AA, rd, ack_c, rdv_c, dq_ack);
      check_eq("oor_wr_ack_cycle", 32'(ack_c), 32'd9);
      check_eq("oor_mem0", 32'(mem[8'h00]), 32'h0C0D);
      check_eq("oor_mem1", 32'(mem[8'h01]), 32'h0A0B);
      do_cmd(1'b0, 23'h080000, 4'b0000, 32'h0, rd, ack_c, rdv_c, dq_ack);
      check_eq("oor_rd_data", rd, 32'h0);
      check_eq("oor_rd_ack_cycle", 32'(ack_c), 32'd9);
      check_eq("oor_rd_rdv_cycle", 32'(rdv_c), 32'd10);
      check_eq("oor_ce_low_cycles", 32'(ce_low_cnt - b_ce), 32'd0);

      // Back-to-back reads of words 0,1,2
      base  = rdv_cyc_q.size();
      start = cyc_g;
      idx   = 0;
      bus.s1_address    = 23'h0;
      bus.s1_chipselect = 1'b1;
      bus.s1_read_n     = 1'b0;
      bus.s1_write_n    = 1'b1;
      for (int k = 0; k < 100 && idx < 3; k++) begin
         @(negedge clk);
         if (!bus.s1_waitrequest) begin
            idx++;
            @(posedge clk); #1;
            if (idx < 3) bus.s1_address = 23'(idx);
            else bus_idle();
         end
      end
      repeat (3) @(posedge clk);
      #1;
      check_eq("b2b_rdv_count", 32'(rdv_cyc_q.size() - base), 32'd3);
      if (rdv_cyc_q.size() - base == 3) begin
         check_eq("b2b_first_rdv", 32'(rdv_cyc_q[base] - start), 32'd10);
         check_eq("b2b_spacing_1", 32'(rdv_cyc_q[base+1] - rdv_cyc_q[base]), 32'd10);
         check_eq("b2b_spacing_2", 32'(rdv_cyc_q[base+2] - rdv_cyc_q[base+1]), 32'd10);
         check_eq("b2b_data_0", rdv_dat_q[base],   32'h0A0B0C0D);
         check_eq("b2b_data_1", rdv_dat_q[base+1], 32'h11110001);
         check_eq("b2b_data_2", rdv_dat_q[base+2], 32'h22220002);
      end

      // Reset asserted in cycle 3 of a write
      bus.s1_address      = 23'h00020;
      bus.s1_byteenable_n = 4'b0000;
      bus.s1_writedata    = 32'hCAFEF00D;
      bus.s1_chipselect   = 1'b1;
      bus.s1_read_n       = 1'b1;
      bus.s1_write_n      = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("abort_we_active", 32'(sram_we_n), 32'h0);
      rst_n = 1'b0;
      #1;
      check_eq("abort_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
      check_eq("abort_dq_z", 32'(sram_dq), 32'hffff);
      bus_idle();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (!bus.s1_waitrequest || bus.s1_readdatavalid) bad++;
      end
      check_eq("abort_no_ack", 32'(bad), 32'd0);
      check_eq("abort_mem_hi", 32'(mem[8'h41]), 32'h0000);
      @(posedge clk); #1;
      do_cmd(1'b1, 23'h00020, 4'b0000, 32'hCAFEF00D, rd, ack_c, rdv_c, dq_ack);
      check_eq("reissue_ack_cycle", 32'(ack_c), 32'd9);
      do_cmd(1'b0, 23'h00020, 4'b0000, 32'h0, rd, ack_c, rdv_c, dq_ack);
      check_eq("reissue_readback", rd, 32'hCAFEF00D);

      check_eq("strobe_edge_viol", 32'(edge_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
